// File: rtl/riscky_pkg.sv
// Shared RV64I pipeline definitions: widths, opcodes, ALU ops and the ID/EX record.
package riscky_pkg;

  localparam int XLEN  = 64;
  localparam int ILEN  = 32;
  localparam int NREGS = 32;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLT   = 4'd5,
    ALU_SLTU  = 4'd6,
    ALU_SLL   = 4'd7,
    ALU_SRL   = 4'd8,
    ALU_SRA   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_J, IMM_U} imm_sel_t;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef struct packed {
    logic            reg_write;
    logic            mem_write;
    logic            jump;
    logic            branch;
    logic            alu_src;
    logic [1:0]      result_src;
    alu_op_t         alu_ctrl;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            illegal;
  } idex_t;

endpackage

// File: rtl/reg_file.sv
// 32 x XLEN register file: two async read ports, one sync write port, x0 reads zero.
module reg_file
  import riscky_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic            wr_en;

  assign wr_en = we && (wa != 5'd0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[wa] = wd;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Bypass lets decode see a value being written back in this same cycle.
  assign rd1 = (ra1 == 5'd0) ? '0 : (wr_en && wa == ra1) ? wd : regs_q[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : (wr_en && wa == ra2) ? wd : regs_q[ra2];

endmodule

// File: rtl/decode.sv
// RV64I decode stage: control decode, register read, immediate extension, ID/EX register.
module decode
  import riscky_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [ILEN-1:0] instr_d,
  input  logic [XLEN-1:0] pc_d,
  input  logic [XLEN-1:0] pc_plus4_d,
  input  logic            flush_e,
  input  logic            reg_write_w,
  input  logic [4:0]      rd_w,
  input  logic [XLEN-1:0] result_w,
  output logic [4:0]      rs1_d,
  output logic [4:0]      rs2_d,
  output logic            reg_write_e,
  output logic            mem_write_e,
  output logic            jump_e,
  output logic            branch_e,
  output logic            alu_src_e,
  output logic [1:0]      result_src_e,
  output logic [3:0]      alu_ctrl_e,
  output logic [2:0]      funct3_e,
  output logic [XLEN-1:0] rd1_e,
  output logic [XLEN-1:0] rd2_e,
  output logic [XLEN-1:0] imm_ext_e,
  output logic [XLEN-1:0] pc_e,
  output logic [XLEN-1:0] pc_plus4_e,
  output logic [4:0]      rs1_e,
  output logic [4:0]      rs2_e,
  output logic [4:0]      rd_e,
  output logic            illegal_e
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rd1, rd2;
  imm_sel_t        imm_sel;
  idex_t           dec, idex_d, idex_q;

  assign opcode = instr_d[6:0];
  assign funct3 = instr_d[14:12];
  assign rs1_d  = instr_d[19:15];
  assign rs2_d  = instr_d[24:20];

  reg_file u_reg_file (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (rs1_d),
    .ra2   (rs2_d),
    .we    (reg_write_w),
    .wa    (rd_w),
    .wd    (result_w),
    .rd1   (rd1),
    .rd2   (rd2)
  );

  // For I-ALU, bit 30 is immediate data except on the right-shift encoding.
  function automatic alu_op_t alu_arith(input logic [2:0] f3, input logic alt, input logic is_r);
    alu_op_t op;
    case (f3)
      3'b000:  op = (is_r && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  always_comb begin
    dec          = '0;
    imm_sel      = IMM_I;
    dec.funct3   = funct3;
    dec.rd1      = rd1;
    dec.rd2      = rd2;
    dec.pc       = pc_d;
    dec.pc_plus4 = pc_plus4_d;
    dec.rs1      = rs1_d;
    dec.rs2      = rs2_d;
    dec.rd       = instr_d[11:7];

    case (opcode)
      OP_R: begin
        dec.reg_write = 1'b1;
        dec.alu_ctrl  = alu_arith(funct3, instr_d[30], 1'b1);
      end
      OP_IMM: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_ctrl  = alu_arith(funct3, instr_d[30], 1'b0);
      end
      OP_LOAD: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = RES_MEM;
      end
      OP_STORE: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        imm_sel       = IMM_S;
      end
      OP_BRANCH: begin
        dec.branch   = 1'b1;
        dec.alu_ctrl = ALU_SUB;
        imm_sel      = IMM_B;
      end
      OP_JAL: begin
        dec.reg_write  = 1'b1;
        dec.jump       = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = RES_PC4;
        imm_sel        = IMM_J;
      end
      OP_JALR: begin
        dec.reg_write  = 1'b1;
        dec.jump       = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = RES_PC4;
      end
      OP_LUI: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_ctrl  = ALU_PASSB;
        imm_sel       = IMM_U;
      end
      default: begin
        dec.illegal = 1'b1;
        dec.funct3  = 3'b000;
      end
    endcase

    case (imm_sel)
      IMM_S:   dec.imm_ext = {{(XLEN-12){instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
      IMM_B:   dec.imm_ext = {{(XLEN-13){instr_d[31]}}, instr_d[31], instr_d[7],
                              instr_d[30:25], instr_d[11:8], 1'b0};
      IMM_J:   dec.imm_ext = {{(XLEN-21){instr_d[31]}}, instr_d[31], instr_d[19:12],
                              instr_d[20], instr_d[30:21], 1'b0};
      IMM_U:   dec.imm_ext = {{(XLEN-32){instr_d[31]}}, instr_d[31:12], 12'b0};
      default: dec.imm_ext = {{(XLEN-12){instr_d[31]}}, instr_d[31:20]};
    endcase
  end

  always_comb begin
    idex_d = dec;
    if (flush_e) idex_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) idex_q <= '0;
    else        idex_q <= idex_d;
  end

  assign reg_write_e  = idex_q.reg_write;
  assign mem_write_e  = idex_q.mem_write;
  assign jump_e       = idex_q.jump;
  assign branch_e     = idex_q.branch;
  assign alu_src_e    = idex_q.alu_src;
  assign result_src_e = idex_q.result_src;
  assign alu_ctrl_e   = idex_q.alu_ctrl;
  assign funct3_e     = idex_q.funct3;
  assign rd1_e        = idex_q.rd1;
  assign rd2_e        = idex_q.rd2;
  assign imm_ext_e    = idex_q.imm_ext;
  assign pc_e         = idex_q.pc;
  assign pc_plus4_e   = idex_q.pc_plus4;
  assign rs1_e        = idex_q.rs1;
  assign rs2_e        = idex_q.rs2;
  assign rd_e         = idex_q.rd;
  assign illegal_e    = idex_q.illegal;

endmodule

// File: tb/tb_decode.sv
// Self-checking bench for decode: directed literal checks plus randomized traffic against a model.
module tb_decode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr_d;
  logic [63:0] pc_d, pc_plus4_d;
  logic        flush_e;
  logic        reg_write_w;
  logic [4:0]  rd_w;
  logic [63:0] result_w;
  logic [4:0]  rs1_d, rs2_d;
  logic        reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e;
  logic [1:0]  result_src_e;
  logic [3:0]  alu_ctrl_e;
  logic [2:0]  funct3_e;
  logic [63:0] rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;
  logic        illegal_e;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  decode dut (
    .clk(clk), .rst_n(rst_n), .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
    .flush_e(flush_e), .reg_write_w(reg_write_w), .rd_w(rd_w), .result_w(result_w),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .reg_write_e(reg_write_e), .mem_write_e(mem_write_e),
    .jump_e(jump_e), .branch_e(branch_e), .alu_src_e(alu_src_e), .result_src_e(result_src_e),
    .alu_ctrl_e(alu_ctrl_e), .funct3_e(funct3_e), .rd1_e(rd1_e), .rd2_e(rd2_e),
    .imm_ext_e(imm_ext_e), .pc_e(pc_e), .pc_plus4_e(pc_plus4_e), .rs1_e(rs1_e),
    .rs2_e(rs2_e), .rd_e(rd_e), .illegal_e(illegal_e)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [63:0] mregs [32];
  bit          exp_valid = 0;
  bit          chk_ctrl, chk_alu, chk_imm, chk_data, chk_f3;
  logic        e_rw, e_mw, e_jump, e_br, e_asrc, e_ill;
  logic [1:0]  e_rsrc;
  logic [3:0]  e_alu;
  logic [2:0]  e_f3;
  logic [63:0] e_rd1, e_rd2, e_imm, e_pc, e_pc4;
  logic [4:0]  e_rs1, e_rs2, e_rd;

  function automatic logic [63:0] model_read(input int idx);
    if (idx == 0) return 64'd0;
    if (reg_write_w && rd_w == 5'(idx)) return result_w;
    return mregs[idx];
  endfunction

  task automatic model_zero();
    {e_rw, e_mw, e_jump, e_br, e_asrc, e_ill} = '0;
    e_rsrc = '0; e_alu = '0; e_f3 = '0;
    {e_rd1, e_rd2, e_imm, e_pc, e_pc4} = '0;
    {e_rs1, e_rs2, e_rd} = '0;
    chk_ctrl = 1; chk_alu = 1; chk_imm = 1; chk_data = 1; chk_f3 = 1;
  endtask

  task automatic model_decode();
    int unsigned op, f3, rs1, rs2;
    logic [63:0] u;
    logic signed [63:0] sx;
    bit r, i, ld, st, br, jal, jalr, lui, legal;
    int alu_tab [8] = '{0, 7, 5, 6, 4, 8, 3, 2};
    u  = 64'(instr_d);
    sx = 64'($signed(instr_d));
    op = instr_d & 32'h7F;
    f3 = (instr_d >> 12) & 7;
    rs1 = (instr_d >> 15) & 31;
    rs2 = (instr_d >> 20) & 31;
    r = (op == 'h33); i = (op == 'h13); ld = (op == 'h03); st = (op == 'h23);
    br = (op == 'h63); jal = (op == 'h6F); jalr = (op == 'h67); lui = (op == 'h37);
    legal = r | i | ld | st | br | jal | jalr | lui;

    e_rw   = r | i | ld | jal | jalr | lui;
    e_mw   = st;
    e_br   = br;
    e_jump = jal | jalr;
    e_asrc = legal & !r & !br;
    e_rsrc = ld ? 2'd1 : (jal | jalr) ? 2'd2 : 2'd0;
    e_ill  = !legal;
    if (r || i) begin
      e_alu = 4'(alu_tab[f3]);
      if (f3 == 5 && instr_d[30]) e_alu = 4'd9;
      if (r && f3 == 0 && instr_d[30]) e_alu = 4'd1;
    end else if (br) e_alu = 4'd1;
    else if (lui) e_alu = 4'd10;
    else e_alu = 4'd0;

    if (st)       e_imm = 64'((sx >>> 25) << 5) | ((u >> 7) & 64'h1F);
    else if (br)  e_imm = 64'((sx >>> 31) << 12) | (((u >> 7) & 1) << 11)
                        | (((u >> 25) & 64'h3F) << 5) | (((u >> 8) & 64'hF) << 1);
    else if (jal) e_imm = 64'((sx >>> 31) << 20) | (((u >> 12) & 64'hFF) << 12)
                        | (((u >> 20) & 1) << 11) | (((u >> 21) & 64'h3FF) << 1);
    else if (lui) e_imm = 64'((sx >>> 12) << 12);
    else          e_imm = 64'(sx >>> 20);

    e_f3  = 3'(f3);
    e_rd1 = model_read(int'(rs1));
    e_rd2 = model_read(int'(rs2));
    e_pc  = pc_d;
    e_pc4 = pc_plus4_d;
    e_rs1 = 5'(rs1); e_rs2 = 5'(rs2); e_rd = 5'((instr_d >> 7) & 31);

    chk_ctrl = 1;
    chk_alu  = legal && !jal;
    chk_imm  = legal && !r;
    chk_data = legal;
    chk_f3   = legal;
  endtask

  always @(negedge clk) begin
    chk("rs1_d", 64'(rs1_d), 64'((instr_d >> 15) & 31));
    chk("rs2_d", 64'(rs2_d), 64'((instr_d >> 20) & 31));
    if (!rst_n) begin
      model_zero();
      for (int k = 0; k < 32; k++) mregs[k] = 64'd0;
    end else begin
      if (flush_e) model_zero();
      else         model_decode();
      if (reg_write_w && rd_w != 0) mregs[rd_w] = result_w;
    end
    exp_valid = 1;
  end

  always @(posedge clk) begin
    #1;
    if (exp_valid) begin
      if (chk_ctrl) begin
        chk("reg_write_e", 64'(reg_write_e), 64'(e_rw));
        chk("mem_write_e", 64'(mem_write_e), 64'(e_mw));
        chk("jump_e", 64'(jump_e), 64'(e_jump));
        chk("branch_e", 64'(branch_e), 64'(e_br));
        chk("alu_src_e", 64'(alu_src_e), 64'(e_asrc));
        chk("result_src_e", 64'(result_src_e), 64'(e_rsrc));
        chk("illegal_e", 64'(illegal_e), 64'(e_ill));
      end
      if (chk_alu) chk("alu_ctrl_e", 64'(alu_ctrl_e), 64'(e_alu));
      if (chk_f3)  chk("funct3_e", 64'(funct3_e), 64'(e_f3));
      if (chk_imm) chk("imm_ext_e", imm_ext_e, e_imm);
      if (chk_data) begin
        chk("rd1_e", rd1_e, e_rd1);
        chk("rd2_e", rd2_e, e_rd2);
        chk("pc_e", pc_e, e_pc);
        chk("pc_plus4_e", pc_plus4_e, e_pc4);
        chk("rs1_e", 64'(rs1_e), 64'(e_rs1));
        chk("rs2_e", 64'(rs2_e), 64'(e_rs2));
        chk("rd_e", 64'(rd_e), 64'(e_rd));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] legal_ops [8] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37};
    logic [6:0] bad_ops [6]   = '{7'h7F, 7'h0F, 7'h17, 7'h73, 7'h1B, 7'h3B};
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 7) == 0) w[6:0] = bad_ops[$urandom_range(0, 5)];
    else                           w[6:0] = legal_ops[$urandom_range(0, 7)];
    return w;
  endfunction

  initial begin
    rst_n = 1'b0; instr_d = 32'hFFF28313; pc_d = 64'h1000; pc_plus4_d = 64'h1004;
    flush_e = 1'b0; reg_write_w = 1'b0; rd_w = 5'd0; result_w = 64'd0;
    tick(); tick();
    chk("lit_rst_reg_write", 64'(reg_write_e), 64'd0);
    chk("lit_rst_alu_src", 64'(alu_src_e), 64'd0);
    chk("lit_rst_imm", imm_ext_e, 64'd0);
    chk("lit_rst_pc", pc_e, 64'd0);

    rst_n = 1'b1; instr_d = 32'h00000013;
    tick();
    chk("lit_nop_rd1", rd1_e, 64'd0);
    chk("lit_nop_alu_src", 64'(alu_src_e), 64'd1);

    reg_write_w = 1'b1; rd_w = 5'd5; result_w = 64'h1234;
    tick();
    reg_write_w = 1'b0; instr_d = 32'hFFF28313;
    tick();
    chk("lit_addi_rd1", rd1_e, 64'h1234);
    chk("lit_addi_imm", imm_ext_e, 64'hFFFFFFFFFFFFFFFF);
    chk("lit_addi_alu", 64'(alu_ctrl_e), 64'd0);
    chk("lit_addi_alu_src", 64'(alu_src_e), 64'd1);
    chk("lit_addi_reg_write", 64'(reg_write_e), 64'd1);
    chk("lit_addi_rd", 64'(rd_e), 64'd6);

    reg_write_w = 1'b1; rd_w = 5'd5; result_w = 64'hAA;
    tick();
    chk("lit_bypass_rd1", rd1_e, 64'hAA);

    rd_w = 5'd0; result_w = 64'hFF; instr_d = 32'h00000013;
    tick();
    reg_write_w = 1'b0; instr_d = 32'h00500093;
    tick();
    chk("lit_x0_rd1", rd1_e, 64'd0);
    chk("lit_x0_imm", imm_ext_e, 64'd5);

    instr_d = 32'hFE208CE3;
    tick();
    chk("lit_beq_branch", 64'(branch_e), 64'd1);
    chk("lit_beq_alu", 64'(alu_ctrl_e), 64'd1);
    chk("lit_beq_imm", imm_ext_e, 64'hFFFFFFFFFFFFFFF8);
    chk("lit_beq_reg_write", 64'(reg_write_e), 64'd0);
    chk("lit_beq_funct3", 64'(funct3_e), 64'd0);

    instr_d = 32'hFFF28313; flush_e = 1'b1;
    tick();
    flush_e = 1'b0;
    chk("lit_flush_reg_write", 64'(reg_write_e), 64'd0);
    chk("lit_flush_alu_src", 64'(alu_src_e), 64'd0);
    chk("lit_flush_rd1", rd1_e, 64'd0);

    instr_d = 32'h0000007F;
    tick();
    chk("lit_ill_illegal", 64'(illegal_e), 64'd1);
    chk("lit_ill_reg_write", 64'(reg_write_e), 64'd0);
    chk("lit_ill_mem_write", 64'(mem_write_e), 64'd0);

    for (int n = 0; n < 3000; n++) begin
      instr_d     = rand_instr();
      pc_d        = {$urandom, $urandom};
      pc_plus4_d  = pc_d + 64'd4;
      flush_e     = ($urandom_range(0, 9) == 0);
      rst_n       = ($urandom_range(0, 79) != 0);
      reg_write_w = $urandom_range(0, 1) == 1;
      rd_w        = ($urandom_range(0, 3) == 0) ? instr_d[19:15] : 5'($urandom);
      result_w    = {$urandom, $urandom};
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decode.md
Name: decode

Overview:
- Decode stage of the 5-stage RV64I pipeline, directly downstream of fetch.
- Consumes the IF/ID outputs (instr_d, pc_d, pc_plus4_d) and decodes the instruction.
- Reads the 32x64 register file and sign-extends the immediate.
- Registers everything into the ID/EX pipeline register for execute; also accepts the writeback port for the register file.

Parameters:
- XLEN, 64, datapath width (from riscky_pkg).
- ILEN, 32, instruction width (from riscky_pkg).
- NREGS, 32, architectural register count; x0 hardwired to zero.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- instr_d  in  ILEN  instruction from IF/ID
- pc_d  in  XLEN  PC of instr_d
- pc_plus4_d  in  XLEN  PC+4 of instr_d
- flush_e  in  1  hazard unit: load a bubble into ID/EX
- reg_write_w  in  1  writeback enable
- rd_w  in  5  writeback destination
- result_w  in  XLEN  writeback data
- rs1_d, rs2_d  out  5  combinational source indices for the hazard unit
- reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e  out  1 each  registered controls
- result_src_e  out  2  00 ALU, 01 memory, 10 PC+4
- alu_ctrl_e  out  4  alu_op_t encoding
- funct3_e  out  3  branch/load/store sub-op
- rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e  out  XLEN  registered data
- rs1_e, rs2_e, rd_e  out  5  registered register indices
- illegal_e  out  1  unsupported opcode flag

Behaviour:
- Supported opcodes:
  - R 0110011, I-ALU 0010011, load 0000011, store 0100011, branch 1100011.
  - jal 1101111, jalr 1100111, lui 0110111.
  - Any other opcode: all controls 0, illegal_e=1 (bubble).
- ALU decode:
  - R-type: instr[30] selects SUB vs ADD and SRA vs SRL.
  - I-ALU: instr[30] selects SRAI only; the shamt is 6 bits (instr[25:20]).
  - load, store, jalr: ADD. Branch: SUB. lui: PASSB.
- Immediates (all sign-extended to XLEN from instr[31]):
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - U: {instr[31:12], 12'b0}.
- Control sets:
  - reg_write: R, I-ALU, load, jal, jalr, lui.
  - mem_write: store.
  - alu_src (use immediate): all except R and branch.
  - result_src: load=01; jal/jalr=10; else 00.
  - jump: jal and jalr.
- Register file:
  - Two asynchronous read ports, one synchronous write port on posedge clk.
  - No write when rd_w=0.
  - Read of x0 always returns 0.
  - Write-through bypass: when reg_write_w=1, rd_w!=0 and rd_w equals the read index, the read port returns result_w in the same cycle.
- ID/EX register, latency 1 cycle. Priority: rst_n low > flush_e > normal capture.
- Reset (rst_n=0 at posedge): every *_e output becomes 0 and all 32 registers clear to 0.
- flush_e=1: all controls and illegal_e = 0. Data fields (rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e, rs*_e, rd_e) = 0.
- Writeback during flush or reset: the register write still occurs during flush; reset wins over write.
- Reset mid-operation discards the in-flight ID/EX contents; no partial state remains.
- rs1_d/rs2_d are driven from instr_d[19:15]/[24:20] regardless of opcode.

Decomposition:
- riscky_pkg additions:
  - alu_op_t (4-bit): ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLTU=6, SLL=7, SRL=8, SRA=9, PASSB=10.
  - opcode constants.
  - imm_sel_t {IMM_I, IMM_S, IMM_B, IMM_J, IMM_U}.
  - result_src constants.
- One sub-module: reg_file (32xXLEN, 2R1W, x0 zero, write-through bypass).
- Control decode and immediate extension stay inline.

Test Plan:
- Reset: hold rst_n=0 two cycles -> all *_e outputs 0; after release, instr 0x00000013 reads rd1_e=0.
- Write x5=0x1234 via reg_write_w, then instr_d=0xFFF28313 (addi x6,x5,-1) -> next cycle:
  - rd1_e=0x1234, imm_ext_e=0xFFFFFFFFFFFFFFFF, alu_ctrl_e=ADD.
  - alu_src_e=1, reg_write_e=1, rd_e=6.
- Bypass: same cycle as decoding 0xFFF28313, reg_write_w=1, rd_w=5, result_w=0xAA -> rd1_e=0xAA.
- x0 write: reg_write_w=1, rd_w=0, result_w=0xFF, then addi reading x0 -> rd1_e=0.
- Branch: instr_d=0xFE208CE3 (beq x1,x2,-8) -> branch_e=1, alu_ctrl_e=SUB, imm_ext_e=0xFFFFFFFFFFFFFFF8, reg_write_e=0, funct3_e=0.
- Bubble/illegal:
  - flush_e=1 with a valid addi -> all controls 0 next cycle.
  - instr_d=0x0000007F -> illegal_e=1, reg_write_e=0, mem_write_e=0.
